// File: rtl/uart_frame_parser.sv
// Framing stage behind the UART receiver: hunts for SOF, buffers a length-prefixed
// payload, verifies the additive checksum and holds good frames for host readout.
module uart_frame_parser #(
   parameter int unsigned MAX_LEN       = 16,
   parameter int unsigned TIMEOUT_TICKS = 640,
   parameter logic [7:0]  SOF           = 8'h7E
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx_done_tick,
   input  logic [7:0] din,
   input  logic       s_tick,
   output logic       frame_valid,
   output logic [7:0] frame_len,
   input  logic [7:0] rd_addr,
   output logic [7:0] rd_data,
   input  logic       frame_ack,
   output logic       err_chk,
   output logic       err_len,
   output logic       err_timeout,
   output logic       err_overrun
);

   localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned CNT_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_PAYLOAD,
      ST_CHK,
      ST_HOLD
   } state_e;

   state_e             state_q, state_d;
   logic [7:0]         len_q, len_d;
   logic [7:0]         frame_len_q, frame_len_d;
   logic [7:0]         sum_q, sum_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               frame_valid_q;
   logic               err_chk_q, err_chk_d;
   logic               err_len_q, err_len_d;
   logic               err_timeout_q, err_timeout_d;
   logic               err_overrun_q, err_overrun_d;
   logic               buf_we_c;
   logic [7:0]         chk_sum_c;
   logic [7:0]         buf_q [MAX_LEN];

   assign chk_sum_c = sum_q + din;

   // Next-state, datapath updates and error pulse generation
   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      frame_len_d   = frame_len_q;
      sum_d         = sum_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      err_chk_d     = 1'b0;
      err_len_d     = 1'b0;
      err_timeout_d = 1'b0;
      err_overrun_d = 1'b0;
      buf_we_c      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_done_tick && din == SOF) begin
               state_d = ST_LEN;
               sum_d   = 8'h00;
               cnt_d   = '0;
            end
         end
         ST_LEN: begin
            if (rx_done_tick) begin
               if (din == 8'h00 || din > 8'(MAX_LEN)) begin
                  err_len_d = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  len_d   = din;
                  sum_d   = din;
                  idx_d   = '0;
                  state_d = ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            if (rx_done_tick) begin
               buf_we_c = 1'b1;
               sum_d    = chk_sum_c;
               if (8'(idx_q) == len_q - 8'd1) begin
                  state_d = ST_CHK;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         ST_CHK: begin
            if (rx_done_tick) begin
               if (chk_sum_c == 8'h00) begin
                  state_d     = ST_HOLD;
                  frame_len_d = len_q;
               end else begin
                  err_chk_d = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
         end
         ST_HOLD: begin
            err_overrun_d = rx_done_tick;
            if (frame_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Inter-byte timeout; an arriving byte takes priority over an expiring tick
      if (state_q == ST_LEN || state_q == ST_PAYLOAD || state_q == ST_CHK) begin
         if (rx_done_tick) begin
            cnt_d = '0;
         end else if (s_tick) begin
            if (cnt_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
               cnt_d         = '0;
               err_timeout_d = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         len_q         <= 8'h00;
         frame_len_q   <= 8'h00;
         sum_q         <= 8'h00;
         idx_q         <= '0;
         cnt_q         <= '0;
         frame_valid_q <= 1'b0;
         err_chk_q     <= 1'b0;
         err_len_q     <= 1'b0;
         err_timeout_q <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         frame_len_q   <= frame_len_d;
         sum_q         <= sum_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         frame_valid_q <= (state_d == ST_HOLD);
         err_chk_q     <= err_chk_d;
         err_len_q     <= err_len_d;
         err_timeout_q <= err_timeout_d;
         err_overrun_q <= err_overrun_d;
      end
   end

   // Payload storage is deliberately left unreset
   always_ff @(posedge clk) begin
      if (buf_we_c) begin
         buf_q[idx_q] <= din;
      end
   end

   assign rd_data     = (rd_addr < 8'(MAX_LEN)) ? buf_q[rd_addr[IDX_W-1:0]] : 8'h00;
   assign frame_valid = frame_valid_q;
   assign frame_len   = frame_len_q;
   assign err_chk     = err_chk_q;
   assign err_len     = err_len_q;
   assign err_timeout = err_timeout_q;
   assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: frame vector table plus hand-built corner sequences,
// with a scoreboard of expected frame/error events matched by a negedge monitor.
module tb_uart_frame_parser;

   localparam int unsigned MAX_LEN       = 16;
   localparam int unsigned TIMEOUT_TICKS = 640;

   localparam int K_GOOD = 0;
   localparam int K_CHK  = 1;
   localparam int K_LEN  = 2;
   localparam int K_TMO  = 3;
   localparam int K_OVR  = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rx_done_tick;
   logic [7:0] din;
   logic       s_tick;
   logic       frame_valid;
   logic [7:0] frame_len;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       frame_ack;
   logic       err_chk, err_len, err_timeout, err_overrun;

   uart_frame_parser #(
      .MAX_LEN      (MAX_LEN),
      .TIMEOUT_TICKS(TIMEOUT_TICKS),
      .SOF          (8'h7E)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rx_done_tick(rx_done_tick),
      .din         (din),
      .s_tick      (s_tick),
      .frame_valid (frame_valid),
      .frame_len   (frame_len),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .frame_ack   (frame_ack),
      .err_chk     (err_chk),
      .err_len     (err_len),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           kind;
      int           exp_len;
      int           pre;
      int           n;
      logic [191:0] data;
   } vec_t;

   typedef struct {
      int         kind;
      logic [7:0] len;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   mon_en   = 1'b0;
   logic fv_prev  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push(input int kind, input int len);
      exp_t e;
      e.kind = kind;
      e.len  = 8'(len);
      sb_q.push_back(e);
   endtask

   task automatic observe(input int kind, input logic [7:0] len);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         $display("FAIL unexpected event: kind %0d seen, none expected", kind);
         return;
      end
      e = sb_q.pop_front();
      check("event kind", 32'(kind), 32'(e.kind));
      if (kind == K_GOOD && e.kind == K_GOOD) check("frame_len", 32'(len), 32'(e.len));
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (err_chk)     observe(K_CHK, 8'h00);
         if (err_len)     observe(K_LEN, 8'h00);
         if (err_timeout) observe(K_TMO, 8'h00);
         if (err_overrun) observe(K_OVR, 8'h00);
         if (frame_valid && !fv_prev) observe(K_GOOD, frame_len);
      end
      fv_prev <= frame_valid;
   end

   function automatic logic [7:0] vbyte(input vec_t v, input int i);
      return v.data[8*(v.n-1-i) +: 8];
   endfunction

   function automatic vec_t mk(input int kind, input int len, input int pre, input int n,
                               input logic [191:0] d);
      vec_t v;
      v.kind = kind; v.exp_len = len; v.pre = pre; v.n = n; v.data = d;
      return v;
   endfunction

   // Builds SOF, LEN, payload, CHK where CHK is the two's complement of LEN + payload sum
   function automatic vec_t mk_good(input int len, input logic [7:0] seed);
      vec_t       v;
      logic [7:0] s;
      logic [7:0] b;
      v.kind = K_GOOD; v.exp_len = len; v.pre = 0; v.n = len + 3;
      v.data = {184'h0, 8'h7E};
      v.data = {v.data[183:0], 8'(len)};
      s = 8'(len);
      for (int k = 0; k < len; k++) begin
         b = seed + 8'(k * 37);
         s = s + b;
         v.data = {v.data[183:0], b};
      end
      v.data = {v.data[183:0], 8'(0) - s};
      return v;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_done_tick = 1'b1;
      din          = b;
      @(posedge clk); #1;
      rx_done_tick = 1'b0;
      din          = 8'($urandom);
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         s_tick = 1'b1;
         @(posedge clk); #1;
      end
      s_tick = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int k = 0;
      while (sb_q.size() != 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (sb_q.size() == 0) n_pass++;
      else begin
         $display("FAIL %s: %0d expected events still pending", name, sb_q.size());
         sb_q.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic read_payload(input vec_t v);
      for (int k = 0; k < v.exp_len; k++) begin
         rd_addr = 8'(k);
         @(negedge clk);
         check("rd_data", 32'(rd_data), 32'(vbyte(v, v.pre + 2 + k)));
      end
      @(posedge clk); #1;
   endtask

   task automatic ack_frame();
      frame_ack = 1'b1;
      @(posedge clk); #1;
      frame_ack = 1'b0;
      check("frame_valid falls after ack", 32'(frame_valid), 32'd0);
   endtask

   task automatic run_vec(input vec_t v, input bit do_ack);
      for (int j = 0; j < v.n; j++) begin
         if (j == v.n - 1) push(v.kind, v.exp_len);
         send_byte(vbyte(v, j), (j == v.n - 1) ? 0 : 1);
      end
      if (v.kind == K_GOOD) check("frame_valid one cycle after CHK", 32'(frame_valid), 32'd1);
      wait_drain("frame event");
      if (v.kind == K_GOOD) begin
         read_payload(v);
         if (do_ack) ack_frame();
      end
   endtask

   initial begin
      vec_t v_ok;
      vec_t v_to;

      reset_n = 1'b0; rx_done_tick = 1'b0; din = 8'h00; s_tick = 1'b0;
      rd_addr = 8'h00; frame_ack = 1'b0;

      v_ok = mk(K_GOOD, 3, 0, 6, 192'({8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97}));
      vecs.push_back(v_ok);
      vecs.push_back(mk(K_CHK, 0, 3, 9,
                        192'({8'h55, 8'hAA, 8'h00, 8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98})));
      vecs.push_back(v_ok);
      vecs.push_back(mk(K_LEN, 0, 0, 2, 192'({8'h7E, 8'h00})));
      vecs.push_back(mk(K_LEN, 0, 0, 2, 192'({8'h7E, 8'h11})));
      vecs.push_back(mk_good(16, 8'h40));
      vecs.push_back(mk(K_GOOD, 2, 0, 5, 192'({8'h7E, 8'h02, 8'h7E, 8'h7E, 8'h02})));
      vecs.push_back(mk(K_GOOD, 1, 0, 4, 192'({8'h7E, 8'h01, 8'hFF, 8'h00})));
      vecs.push_back(mk_good(7, 8'hC3));

      repeat (2) begin @(posedge clk); #1; end
      check("reset frame_valid", 32'(frame_valid), 32'd0);
      check("reset frame_len", 32'(frame_len), 32'd0);
      check("reset err flags", 32'({err_chk, err_len, err_timeout, err_overrun}), 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], 1'b1);

      // Overrun while held, then overrun coinciding with ack
      run_vec(v_ok, 1'b0);
      push(K_OVR, 0);
      send_byte(8'h55, 0);
      check("err_overrun pulse", 32'(err_overrun), 32'd1);
      wait_drain("overrun");
      check("held after overrun", 32'(frame_valid), 32'd1);
      check("len after overrun", 32'(frame_len), 32'd3);
      read_payload(v_ok);
      push(K_OVR, 0);
      frame_ack = 1'b1; rx_done_tick = 1'b1; din = 8'h7E;
      @(posedge clk); #1;
      frame_ack = 1'b0; rx_done_tick = 1'b0;
      check("valid drops on ack with overrun", 32'(frame_valid), 32'd0);
      wait_drain("overrun with ack");
      run_vec(v_ok, 1'b1);

      // Timeout after exactly TIMEOUT_TICKS idle ticks
      send_byte(8'h7E, 1); send_byte(8'h02, 1); send_byte(8'hAA, 1);
      ticks(TIMEOUT_TICKS - 1);
      push(K_TMO, 0);
      ticks(1);
      check("err_timeout on final tick", 32'(err_timeout), 32'd1);
      wait_drain("timeout");
      run_vec(v_ok, 1'b1);

      // Byte coinciding with the expiring tick keeps the frame alive
      send_byte(8'h7E, 1); send_byte(8'h02, 1); send_byte(8'hAA, 1);
      ticks(TIMEOUT_TICKS - 1);
      s_tick = 1'b1; rx_done_tick = 1'b1; din = 8'hBB;
      @(posedge clk); #1;
      s_tick = 1'b0; rx_done_tick = 1'b0;
      check("no timeout on coinciding byte", 32'(err_timeout), 32'd0);
      ticks(TIMEOUT_TICKS - 1);
      v_to = mk(K_GOOD, 2, 0, 5, 192'({8'h7E, 8'h02, 8'hAA, 8'hBB, 8'h99}));
      push(K_GOOD, 2);
      send_byte(8'h99, 0);
      check("frame_valid after late CHK", 32'(frame_valid), 32'd1);
      wait_drain("coincide frame");
      read_payload(v_to);
      ack_frame();

      // Reset mid-payload discards silently
      send_byte(8'h7E, 1); send_byte(8'h03, 1); send_byte(8'h11, 1);
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      check("mid reset frame_valid", 32'(frame_valid), 32'd0);
      check("mid reset frame_len", 32'(frame_len), 32'd0);
      check("mid reset err flags", 32'({err_chk, err_len, err_timeout, err_overrun}), 32'd0);
      run_vec(v_ok, 1'b1);

      repeat (20) begin @(posedge clk); #1; end
      check("scoreboard empty at end", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
